trigger_capture: RTL and testbench

TRIGGER_CAPTURE -- requirements
Module: trigger_capture

---
 rtl/trigger_capture.sv | 181 ++++++++++++++++++
 tb/tb_trigger_capture.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/trigger_capture.sv
// Trigger capture buffer: records a frame of DEPTH ADC samples around a
// level-crossing trigger, with PRE samples before the trigger sample and
// DEPTH-PRE-1 after it. The frame is read back by logical index, where
// index 0 is the oldest sample.
module trigger_capture #(
    parameter int DEPTH = 256,
    parameter int DW    = 12
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     sample_valid,
    input  logic [DW-1:0]            sample_data,
    input  logic [DW-1:0]            trig_level,
    input  logic                     trig_slope,
    input  logic                     arm,
    output logic                     busy,
    output logic                     capture_done,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [DW-1:0]            rd_data
);
    localparam int AW     = $clog2(DEPTH);
    localparam int PRE    = DEPTH / 2;
    localparam int POST_N = DEPTH - PRE - 1;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_PRE_FILL  = 3'd1,
        S_WAIT_TRIG = 3'd2,
        S_POST      = 3'd3,
        S_DONE      = 3'd4
    } state_t;

    state_t         state_q, state_d;
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  cnt_q, cnt_d;
    logic [AW-1:0]  start_q, start_d;
    logic [DW-1:0]  prev_q, prev_d;
    logic           prev_valid_q, prev_valid_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic [DW-1:0]  rd_data_q;
    logic           wr_en_s;
    logic           trig_hit_s;
    logic [DW-1:0]  mem [DEPTH];

    // Trigger detection: unsigned level crossing between the stored and current sample
    always_comb begin
        if (trig_slope) begin
            trig_hit_s = prev_valid_q && (prev_q > trig_level) && (sample_data <= trig_level);
        end else begin
            trig_hit_s = prev_valid_q && (prev_q < trig_level) && (sample_data >= trig_level);
        end
    end

    // Next-state logic: capture sequencing, write pointer, counters and prev sample
    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        cnt_d        = cnt_q;
        start_d      = start_q;
        prev_d       = prev_q;
        prev_valid_d = prev_valid_q;
        wr_en_s      = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (arm) begin
                    // a sample arriving with arm is deliberately dropped
                    state_d      = S_PRE_FILL;
                    wr_ptr_d     = '0;
                    cnt_d        = '0;
                    prev_valid_d = 1'b0;
                end else if (sample_valid) begin
                    prev_d       = sample_data;
                    prev_valid_d = 1'b1;
                end else begin
                    state_d = state_q;
                end
            end
            S_PRE_FILL: begin
                if (sample_valid) begin
                    wr_en_s      = 1'b1;
                    wr_ptr_d     = wr_ptr_q + AW'(1);
                    prev_d       = sample_data;
                    prev_valid_d = 1'b1;
                    if (cnt_q == AW'(PRE - 1)) begin
                        state_d = S_WAIT_TRIG;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + AW'(1);
                    end
                end else begin
                    state_d = state_q;
                end
            end
            S_WAIT_TRIG: begin
                if (sample_valid) begin
                    wr_en_s      = 1'b1;
                    wr_ptr_d     = wr_ptr_q + AW'(1);
                    prev_d       = sample_data;
                    prev_valid_d = 1'b1;
                    if (trig_hit_s) begin
                        // the frame starts PRE samples before the trigger slot
                        start_d = wr_ptr_q - AW'(PRE);
                        cnt_d   = '0;
                        state_d = S_POST;
                    end else begin
                        state_d = S_WAIT_TRIG;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            S_POST: begin
                if (sample_valid) begin
                    wr_en_s      = 1'b1;
                    wr_ptr_d     = wr_ptr_q + AW'(1);
                    prev_d       = sample_data;
                    prev_valid_d = 1'b1;
                    if (cnt_q == AW'(POST_N - 1)) begin
                        state_d = S_DONE;
                    end else begin
                        cnt_d = cnt_q + AW'(1);
                    end
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d == S_PRE_FILL) || (state_d == S_WAIT_TRIG) || (state_d == S_POST);
        done_d = (state_d == S_DONE);
    end

    // State and control registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            wr_ptr_q     <= '0;
            cnt_q        <= '0;
            start_q      <= '0;
            prev_q       <= '0;
            prev_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            cnt_q        <= cnt_d;
            start_q      <= start_d;
            prev_q       <= prev_d;
            prev_valid_q <= prev_valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    // Sample memory write port; contents survive reset, writes are blocked during it
    always_ff @(posedge clk) begin
        if (rst_n && wr_en_s) begin
            mem[wr_ptr_q] <= sample_data;
        end
    end

    // Registered read port translating the logical index to a physical slot
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= mem[start_q + rd_addr];
        end
    end

    assign busy         = busy_q;
    assign capture_done = done_q;
    assign rd_data      = rd_data_q;

endmodule

// File: tb/tb_trigger_capture.sv
// Self-checking bench for trigger_capture: a sample-history model predicts
// busy, capture_done and rd_data every cycle; directed scenarios add
// hand-computed frame values.
module tb_trigger_capture;
    localparam int DEPTH = 256;
    localparam int DW    = 12;
    localparam int PRE   = DEPTH / 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          sample_valid;
    logic [DW-1:0] sample_data;
    logic [DW-1:0] trig_level;
    logic          trig_slope;
    logic          arm;
    logic          busy;
    logic          capture_done;
    logic [7:0]    rd_addr;
    logic [DW-1:0] rd_data;

    int checks = 0;
    int errors = 0;

    trigger_capture #(.DEPTH(DEPTH), .DW(DW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sample_valid (sample_valid),
        .sample_data  (sample_data),
        .trig_level   (trig_level),
        .trig_slope   (trig_slope),
        .arm          (arm),
        .busy         (busy),
        .capture_done (capture_done),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data)
    );

    always #5 clk = ~clk;

    // ---------------- model: history of samples accepted since arm ----------
    int hist[$];
    int trig_pos = -1;
    bit armed = 1'b0;
    int start_m = 0;
    int mem_m [DEPTH];
    bit mem_k [DEPTH];
    int exp_rd;
    bit rd_ok;

    function automatic bit model_done();
        return armed && (trig_pos >= 0) && (hist.size() == trig_pos + DEPTH - PRE);
    endfunction

    task automatic model_step();
        int sz, pv, d, lvl;
        bit hit;
        d   = int'(sample_data);
        lvl = int'(trig_level);
        if (!rst_n) begin
            armed = 1'b0;
            hist.delete();
            trig_pos = -1;
            start_m = 0;
        end else if ((!armed || model_done()) && arm) begin
            armed = 1'b1;
            hist.delete();
            trig_pos = -1;
        end else if (armed && !model_done() && sample_valid) begin
            sz = hist.size();
            if (trig_pos < 0 && sz >= PRE) begin
                pv  = hist[sz-1];
                hit = trig_slope ? (pv > lvl && d <= lvl) : (pv < lvl && d >= lvl);
                if (hit) begin
                    trig_pos = sz;
                    start_m  = (sz - PRE) % DEPTH;
                end
            end
            mem_m[sz % DEPTH] = d;
            mem_k[sz % DEPTH] = 1'b1;
            hist.push_back(d);
        end
    endtask

    // Compare process: advance the model on each edge, then check DUT outputs
    always @(posedge clk) begin
        rd_ok  = mem_k[(start_m + int'(rd_addr)) % DEPTH];
        exp_rd = mem_m[(start_m + int'(rd_addr)) % DEPTH];
        if (!rst_n) begin
            rd_ok  = 1'b1;
            exp_rd = 0;
        end
        model_step();
        #1;
        checks++;
        if (busy !== (armed && !model_done())) begin
            errors++;
            $display("FAIL busy: got %0b expected %0b at %0t", busy, armed && !model_done(), $time);
        end
        checks++;
        if (capture_done !== model_done()) begin
            errors++;
            $display("FAIL capture_done: got %0b expected %0b at %0t", capture_done, model_done(), $time);
        end
        if (rd_ok) begin
            checks++;
            if (rd_data !== DW'(exp_rd)) begin
                errors++;
                $display("FAIL rd_data: got %0d expected %0d at %0t", rd_data, exp_rd, $time);
            end
        end
    end

    // ---------------- directed stimulus helpers -----------------------------
    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic put(input int d, input int gap);
        @(negedge clk);
        sample_valid = 1'b1;
        sample_data  = DW'(d);
        @(negedge clk);
        sample_valid = 1'b0;
        for (int g = 1; g < gap; g++) @(negedge clk);
    endtask

    task automatic pulse_arm();
        @(negedge clk);
        arm = 1'b1;
        @(negedge clk);
        arm = 1'b0;
    endtask

    task automatic rd_chk(input string name, input int a, input int exp);
        @(negedge clk);
        rd_addr = 8'(a);
        @(negedge clk);
        chk(name, int'(rd_data), exp);
    endtask

    initial begin
        rst_n        = 1'b0;
        arm          = 1'b0;
        sample_valid = 1'b0;
        sample_data  = '0;
        trig_level   = 12'd300;
        trig_slope   = 1'b0;
        rd_addr      = 8'd0;
        for (int i = 0; i < DEPTH; i++) mem_k[i] = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(capture_done), 0);
        chk("reset_rd", int'(rd_data), 0);
        rst_n = 1'b1;

        // Rising ramp, one sample every 3 clocks
        pulse_arm();
        for (int i = 0; i < 300; i++) put(i, 3);
        chk("ramp_busy_pre_trig", int'(busy), 1);
        for (int i = 300; i < 427; i++) put(i, 3);
        chk("ramp_not_done_early", int'(capture_done), 0);
        put(427, 3);
        chk("ramp_done", int'(capture_done), 1);
        rd_chk("ramp_rd0", 0, 172);
        rd_chk("ramp_rd128", 128, 300);
        rd_chk("ramp_rd255", 255, 427);

        // Re-arm from DONE with a coincident sample that must be dropped
        @(negedge clk);
        arm = 1'b1; sample_valid = 1'b1; sample_data = 12'd999;
        @(negedge clk);
        arm = 1'b0; sample_valid = 1'b0;
        chk("rearm_busy", int'(busy), 1);
        chk("rearm_done", int'(capture_done), 0);
        // crossing of 300 falls inside the fill: no trigger
        for (int i = 250; i < 390; i++) put(i, 1);
        chk("early_cross_ignored", int'(busy), 1);
        pulse_arm();
        for (int i = 390; i < 400; i++) put(i, 1);
        put(100, 1);
        put(350, 1);
        for (int i = 0; i < 127; i++) put(351 + i, 1);
        chk("wait_arm_done", int'(capture_done), 1);
        rd_chk("wait_arm_rd128", 128, 350);
        rd_chk("wait_arm_rd127", 127, 100);
        rd_chk("wait_arm_rd0", 0, 273);

        // Step at sample 128 after a fill of 0..127
        pulse_arm();
        for (int i = 0; i < 128; i++) put(i, 1);
        put(500, 1);
        for (int i = 0; i < 127; i++) put(600 + i, 1);
        rd_chk("step_rd128", 128, 500);
        rd_chk("step_rd127", 127, 127);
        rd_chk("step_rd0", 0, 0);

        // Falling ramp from 4000 in steps of 10
        trig_level = 12'd2000;
        trig_slope = 1'b1;
        pulse_arm();
        for (int k = 0; k < 328; k++) put(4000 - 10 * k, 1);
        chk("fall_done", int'(capture_done), 1);
        rd_chk("fall_rd128", 128, 2000);
        rd_chk("fall_rd127", 127, 2010);

        // Equality edges on a rising trigger at 300
        trig_level = 12'd300;
        trig_slope = 1'b0;
        pulse_arm();
        for (int i = 0; i < 128; i++) put(300, 1);
        put(301, 1);
        put(299, 1);
        put(300, 1);
        for (int i = 0; i < 127; i++) put(0, 1);
        chk("eq_done", int'(capture_done), 1);
        rd_chk("eq_rd128", 128, 300);
        rd_chk("eq_rd127", 127, 299);
        rd_chk("eq_rd126", 126, 301);

        // Reset during POST aborts the capture without further writes
        pulse_arm();
        for (int i = 0; i < 128; i++) put(0, 1);
        put(400, 1);
        for (int i = 0; i < 20; i++) put(1, 1);
        chk("post_busy", int'(busy), 1);
        @(negedge clk);
        rst_n = 1'b0; sample_valid = 1'b1; sample_data = 12'hABC;
        @(negedge clk);
        rst_n = 1'b1; sample_valid = 1'b0;
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(capture_done), 0);
        chk("abort_rd", int'(rd_data), 0);
        rd_addr = 8'd149;
        for (int i = 0; i < 4; i++) put(12'hABC, 1);
        @(negedge clk);
        chk("abort_no_write", int'(rd_data == 12'hABC), 0);
        chk("idle_busy", int'(busy), 0);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
